fetch_pc_ctrl: RTL and testbench

Fetch-stage PC controller, directly downstream of the branch target/predict block. It owns the fetch PC register and drives `fpc` back into the BTB. It accepts the BTB's `next_pc`/`pred` each cycle and records every fetched instruction's predicted successor in an in-flight queue. When the instruction reaches EX, it compares that prediction against the resolved outcome and, on mismatch, redirects the PC and flushes the front end.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pred_queue.sv | 51 +++++
 rtl/fetch_pc_ctrl.sv | 84 ++++++++
 tb/tb_fetch_pc_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC controller and its in-flight queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_next;
        logic        pred;
    } ifq_entry_t;

endpackage

// File: rtl/pred_queue.sv
// Circular FIFO of fetched-instruction predictions, from fetch to EX.
module pred_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  ifq_entry_t din,
    output ifq_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    ifq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            r_mem[r_tail] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + AW'(1);
            if (pop)  r_head <= r_head + AW'(1);
            r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head  = r_mem[r_head];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register, EX-time prediction check, front-end redirect/flush and perf counters.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      next_pc,
    input  logic             pred,
    input  logic             stall,
    input  logic             ex_adv,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic [31:0]      fpc,
    output logic             fetch_valid,
    output logic [31:0]      epc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    logic [31:0]      r_fpc;
    logic             r_flush;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    ifq_entry_t  w_head;
    ifq_entry_t  w_din;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_mispred;
    logic [31:0] w_actual_next;
    logic        w_unused_pred;

    assign w_pop         = ex_adv & ~w_empty;
    assign w_actual_next = (ex_is_branch & ex_taken) ? ex_target : (w_head.pc + PC_INC);
    assign w_mispred     = w_pop & (w_actual_next != w_head.pred_next);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push        = ~stall & ~(w_full & ~w_pop) & ~w_mispred;
    assign w_din         = '{pc: r_fpc, pred_next: next_pc, pred: pred};
    assign w_unused_pred = w_head.pred;

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .clear (w_mispred),
        .din   (w_din),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fpc         <= RESET_PC;
            r_flush       <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_mispred)   r_fpc <= w_actual_next;
            else if (w_push) r_fpc <= next_pc;
            r_flush <= w_mispred;
            if (w_pop && ex_is_branch && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_mispred && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign fpc         = r_fpc;
    assign fetch_valid = w_push;
    assign epc         = w_empty ? 32'h0 : w_head.pc;
    assign flush       = r_flush;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench: driver predicts per-cycle outputs from a queue-level model, monitor compares.
module tb_fetch_pc_ctrl;
    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [31:0]      next_pc = '0;
    logic             pred = 1'b0;
    logic             stall = 1'b1;
    logic             ex_adv = 1'b0;
    logic             ex_is_branch = 1'b0;
    logic             ex_taken = 1'b0;
    logic [31:0]      ex_target = '0;
    logic [31:0]      fpc;
    logic             fetch_valid;
    logic [31:0]      epc;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    fetch_pc_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .next_pc(next_pc), .pred(pred), .stall(stall),
        .ex_adv(ex_adv), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .fpc(fpc), .fetch_valid(fetch_valid), .epc(epc),
        .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred_next;
    } m_entry_t;

    typedef struct {
        logic [31:0] fpc;
        logic        fv;
        logic [31:0] epc;
        logic        flush;
        int          bcnt;
        int          mcnt;
    } exp_t;

    m_entry_t    mq[$];
    exp_t        sbq[$];
    logic [31:0] m_fpc;
    logic        m_flush;
    int          m_bcnt, m_mcnt;
    int          total = 0;
    int          bad   = 0;
    int          sat_max;
    bit          driver_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare whatever the driver predicted for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("fpc",         fpc,                   e.fpc);
                chk("fetch_valid", 32'(fetch_valid),      32'(e.fv));
                chk("epc",         epc,                   e.epc);
                chk("flush",       32'(flush),            32'(e.flush));
                chk("branch_cnt",  32'(branch_cnt),       32'(e.bcnt));
                chk("mispred_cnt", 32'(mispred_cnt),      32'(e.mcnt));
            end
        end
    end

    function automatic void model_reset();
        mq.delete();
        m_fpc   = RESET_PC;
        m_flush = 1'b0;
        m_bcnt  = 0;
        m_mcnt  = 0;
    endfunction

    // Called at posedge+1; asserts reset mid-cycle and checks the asynchronous effect.
    task automatic do_reset();
        exp_t e;
        stall  = 1'b1;
        ex_adv = 1'b0;
        #1 rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_async_fpc",   fpc,               RESET_PC);
        chk("rst_async_flush", 32'(flush),        32'h0);
        chk("rst_async_bcnt",  32'(branch_cnt),   32'h0);
        chk("rst_async_mcnt",  32'(mispred_cnt),  32'h0);
        e = '{fpc: m_fpc, fv: 1'b0, epc: 32'h0, flush: 1'b0, bcnt: 0, mcnt: 0};
        sbq.push_back(e);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // One clock of stimulus: predict outputs, queue them, advance the model.
    task automatic cycle(input logic st, input logic [31:0] np, input logic pr,
                         input logic adv, input logic br, input logic tk,
                         input logic [31:0] tgt);
        exp_t        e;
        m_entry_t    h;
        bit          do_pop, mis, do_push;
        logic [31:0] actual;
        stall = st; next_pc = np; pred = pr;
        ex_adv = adv; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
        do_pop = adv && (mq.size() > 0);
        mis = 0;
        actual = '0;
        if (do_pop) begin
            h = mq[0];
            actual = (br && tk) ? tgt : h.pc + 32'd4;
            mis = (actual != h.pred_next);
        end
        do_push = !st && !((mq.size() == DEPTH) && !do_pop) && !mis;
        e = '{fpc: m_fpc, fv: do_push, epc: (mq.size() > 0) ? mq[0].pc : 32'h0,
              flush: m_flush, bcnt: m_bcnt, mcnt: m_mcnt};
        sbq.push_back(e);
        if (do_pop) begin
            void'(mq.pop_front());
            if (br && m_bcnt < sat_max) m_bcnt++;
            if (mis && m_mcnt < sat_max) m_mcnt++;
            $display("ex pc=%08h br=%0d tk=%0d actual=%08h pred_next=%08h mis=%0d",
                     h.pc, br, tk, actual, h.pred_next, mis);
        end
        if (mis) begin
            mq.delete();
            m_fpc = actual;
        end else if (do_push) begin
            mq.push_back('{pc: m_fpc, pred_next: np});
            m_fpc = np;
        end
        m_flush = mis;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        st, adv, br, tk, pr;
        logic [31:0] np, tgt;
        sat_max = (1 << CNT_W) - 1;
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        do_reset();

        // Sequential fetch fills the queue, then holds at 16.
        repeat (5) cycle(0, m_fpc + 32'd4, 0, 0, 0, 0, 0);
        repeat (4) cycle(1, 0, 0, 1, 0, 0, 0);

        // pc=40 predicted to 48, resolved taken to 48: correct.
        cycle(0, 32'd40, 1, 0, 0, 0, 0);
        cycle(0, 32'd48, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 1, 32'd40);
        cycle(1, 0, 0, 1, 1, 1, 32'd48);

        // Same entry resolved not-taken: redirect to 44 with flush.
        cycle(0, 32'd40, 1, 0, 0, 0, 0);
        cycle(0, 32'd48, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 1, 32'd40);
        cycle(1, 0, 0, 1, 1, 0, 32'd48);
        cycle(0, 32'd48, 0, 0, 0, 0, 0);
        cycle(0, m_fpc + 32'd4, 0, 0, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 1, 0, 0, 0);

        // pc=72 predicted 64, resolved taken to 80, with stall held through the flush.
        cycle(0, 32'd72, 1, 0, 0, 0, 0);
        cycle(0, 32'd64, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 1, 32'd72);
        cycle(1, 0, 0, 1, 1, 1, 32'd80);
        cycle(1, 32'd84, 0, 0, 0, 0, 0);
        cycle(0, 32'd84, 0, 0, 0, 0, 0);

        // Full queue with push+pop together, then pops beyond empty.
        repeat (4) cycle(0, m_fpc + 32'd4, 0, 0, 0, 0, 0);
        cycle(0, m_fpc + 32'd4, 0, 1, 0, 0, 0);
        cycle(0, m_fpc + 32'd4, 0, 0, 0, 0, 0);
        repeat (6) cycle(1, 0, 0, 1, 1, 1, 32'h0);

        // Reset mid-fill.
        repeat (2) cycle(0, m_fpc + 32'd4, 0, 0, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 500; i++) begin
            if (i == 300) do_reset();
            st  = ($urandom_range(0, 3) == 0);
            adv = ($urandom_range(0, 4) < 2);
            br  = $urandom_range(0, 1);
            tk  = $urandom_range(0, 1);
            pr  = $urandom_range(0, 1);
            np  = ($urandom_range(0, 9) < 7) ? m_fpc + 32'd4 : {22'h0, 8'($urandom), 2'b00};
            tgt = {22'h0, 8'($urandom), 2'b00};
            if (mq.size() > 0 && $urandom_range(0, 2) != 0 && br && tk) tgt = mq[0].pred_next;
            cycle(st, np, pr, adv, br, tk, tgt);
        end
        driver_done = 1;
    end

    initial begin
        int guard = 0;
        wait (driver_done);
        while (sbq.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
